modulation_controller: RTL and testbench

Sequences one refresh pass of the modulation buffer. It walks all DEPTH transducer indices and reads each raw duty/phase pair from the upstream RAM. It scales the duty by the current modulation sample and streams the results serially into the buffer's shadow arrays, framed by START/DONE. It sits between the normal/STM duty-phase source and modulation_buffer, in the 20.48 MHz domain.

---
 rtl/modulation_controller.sv | 131 +++++++++++++
 tb/tb_modulation_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulation_controller.sv
// modulation_controller: walks all DEPTH transducer indices, scales each raw duty by the pass modulation sample, streams duty/phase to modulation_buffer framed by START/DONE.
// Latency: data for ADDR=i leaves 2 cycles later on DOUT_*; a pass runs DEPTH+3 cycles from the UPDATE edge to DONE.
// Backpressure: none downstream; UPDATE while busy queues one request, further requests are dropped and flagged on sticky OVERRUN.
module modulation_controller #(
   parameter int WIDTH     = 13,
   parameter int DEPTH     = 249,
   parameter int MOD_WIDTH = 8,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 UPDATE,
   input  logic [MOD_WIDTH-1:0] MOD,
   output logic [AW-1:0]        ADDR,
   input  logic [WIDTH-1:0]     DUTY_IN,
   input  logic [WIDTH-1:0]     PHASE_IN,
   output logic                 START,
   output logic                 DOUT_VALID,
   output logic [AW-1:0]        DOUT_IDX,
   output logic [WIDTH-1:0]     DUTY_OUT,
   output logic [WIDTH-1:0]     PHASE_OUT,
   output logic                 DONE,
   output logic                 BUSY,
   output logic                 OVERRUN
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;

   state_t                   state;
   state_t                   state_n;
   logic                     launch;
   logic                     pending;
   logic                     drain_cnt;
   logic [MOD_WIDTH-1:0]     mod_reg;
   logic                     rd_vld;
   logic [AW-1:0]            rd_idx;
   logic [MOD_WIDTH:0]       scale;
   logic [WIDTH+MOD_WIDTH:0] product;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   assign BUSY = (state != IDLE);
   assign DONE = (state == COMMIT);

   // Next-state decode; launch marks the edge that begins a new pass.
   always_comb begin
      state_n = state;
      launch  = 1'b0;
      case (state)
         IDLE: begin
            if (UPDATE) begin
               launch  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (ADDR == LAST_ADDR) state_n = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt) state_n = COMMIT;
         end
         COMMIT: begin
            // A request arriving in the commit cycle itself is treated as pending.
            if (pending || UPDATE) begin
               launch  = 1'b1;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sequencer state, read address, modulation latch and request bookkeeping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         ADDR      <= '0;
         START     <= 1'b0;
         mod_reg   <= '0;
         pending   <= 1'b0;
         OVERRUN   <= 1'b0;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_n;
         START     <= launch;
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         if (launch) begin
            mod_reg <= MOD;
            ADDR    <= '0;
         end else if (state == RUN && ADDR != LAST_ADDR) begin
            ADDR <= ADDR + AW'(1);
         end
         if (state == COMMIT) begin
            // Pending is consumed here; a second request on top of it is lost.
            pending <= 1'b0;
            if (UPDATE && pending) OVERRUN <= 1'b1;
         end else if (state != IDLE && UPDATE) begin
            if (pending) OVERRUN <= 1'b1;
            else         pending <= 1'b1;
         end
      end
   end

   // mod_reg+1 lets full-scale modulation pass duty through untouched.
   assign scale   = {1'b0, mod_reg} + {{MOD_WIDTH{1'b0}}, 1'b1};
   assign product = {{(MOD_WIDTH+1){1'b0}}, DUTY_IN} * {{WIDTH{1'b0}}, scale};

   // Two-stage output pipe: RAM read cycle, then registered scaled result.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_vld     <= 1'b0;
         rd_idx     <= '0;
         DOUT_VALID <= 1'b0;
         DOUT_IDX   <= '0;
         DUTY_OUT   <= '0;
         PHASE_OUT  <= '0;
      end else begin
         rd_vld     <= (state == RUN);
         rd_idx     <= ADDR;
         DOUT_VALID <= rd_vld;
         if (rd_vld) begin
            DOUT_IDX  <= rd_idx;
            DUTY_OUT  <= WIDTH'(product >> MOD_WIDTH);
            PHASE_OUT <= PHASE_IN;
         end
      end
   end

endmodule

// File: tb/tb_modulation_controller.sv
// tb_modulation_controller: randomized scoreboard bench for modulation_controller.
// Stimulus pushes expected START/DONE/output records from a pass-level request model.
// A negedge monitor pops and compares whenever the DUT presents START, DONE or DOUT_VALID.
module tb_modulation_controller;

   localparam int WIDTH     = 13;
   localparam int DEPTH     = 249;
   localparam int MOD_WIDTH = 8;
   localparam int AW        = $clog2(DEPTH);
   localparam int PASS_LEN  = DEPTH + 3;
   localparam int NEVER     = 32'h7fff_ffff;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 update;
   logic [MOD_WIDTH-1:0] mod;
   logic [AW-1:0]        addr;
   logic [WIDTH-1:0]     duty_in;
   logic [WIDTH-1:0]     phase_in;
   logic                 start;
   logic                 dout_valid;
   logic [AW-1:0]        dout_idx;
   logic [WIDTH-1:0]     duty_out;
   logic [WIDTH-1:0]     phase_out;
   logic                 done;
   logic                 busy;
   logic                 overrun;

   modulation_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MOD_WIDTH(MOD_WIDTH)) dut (
      .CLK(clk), .RST(rst), .UPDATE(update), .MOD(mod), .ADDR(addr),
      .DUTY_IN(duty_in), .PHASE_IN(phase_in), .START(start),
      .DOUT_VALID(dout_valid), .DOUT_IDX(dout_idx), .DUTY_OUT(duty_out),
      .PHASE_OUT(phase_out), .DONE(done), .BUSY(busy), .OVERRUN(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Upstream RAM: one-cycle registered read.
   int duty_mem  [256];
   int phase_mem [256];
   always @(posedge clk) begin
      duty_in  <= WIDTH'(duty_mem[addr]);
      phase_in <= WIDTH'(phase_mem[addr]);
   end

   typedef struct {
      int cyc;
      int idx;
      int duty;
      int phase;
   } exp_t;

   exp_t exp_q   [$];
   int   start_q [$];
   int   done_q  [$];
   int   pass_l  [$];
   int   ovr_cycle = NEVER;
   int   pass_mod  = 0;

   int   checks   = 0;
   int   failures = 0;
   int   done_seen = 0;
   bit   mon_en   = 1'b0;
   int   shadow   [DEPTH];
   int   committed[DEPTH];

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, expv);
      end
   endtask

   task automatic flag(input string name, input longint act, input longint expv);
      checks++;
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, expv);
   endtask

   // Pass-level model: a pass launched at L shows START at L+1, outputs i at L+3+i, DONE at L+DEPTH+3.
   task automatic launch(input int l);
      exp_t e;
      pass_l.push_back(l);
      start_q.push_back(l + 1);
      done_q.push_back(l + PASS_LEN);
      for (int i = 0; i < DEPTH; i++) begin
         e.cyc   = l + 3 + i;
         e.idx   = i;
         e.duty  = (duty_mem[i] * (pass_mod + 1)) / 256;
         e.phase = phase_mem[i];
         exp_q.push_back(e);
      end
   endtask

   // One queued request at most; the queued pass launches at the running pass's DONE cycle.
   task automatic model_req(input int t);
      int l;
      int d;
      if (pass_l.size() == 0) begin
         launch(t);
      end else begin
         l = pass_l[$];
         d = l + PASS_LEN;
         if (t <= l) begin
            if (ovr_cycle > t + 1) ovr_cycle = t + 1;
         end else if (t <= d) begin
            launch(d);
         end else begin
            launch(t);
         end
      end
   endtask

   function automatic bit exp_busy(input int c);
      foreach (pass_l[k])
         if (c >= pass_l[k] + 1 && c <= pass_l[k] + PASS_LEN) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: per-cycle BUSY/OVERRUN plus scoreboard pops on START, DONE and DOUT_VALID.
   always @(negedge clk) begin
      exp_t e;
      int   c;
      if (mon_en) begin
         c = cyc;
         check("busy", busy, exp_busy(c));
         check("overrun", overrun, (c >= ovr_cycle) ? 1 : 0);
         if (start && done) flag("start_done_same_cycle", 1, 0);
         while (start_q.size() > 0 && start_q[0] < c) flag("start_missing", c, start_q.pop_front());
         while (done_q.size() > 0 && done_q[0] < c)   flag("done_missing", c, done_q.pop_front());
         while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
            e = exp_q.pop_front();
            flag("dout_missing_idx", c, e.idx);
         end
         if (start) begin
            if (start_q.size() == 0) flag("start_unexpected", c, -1);
            else check("start_cycle", c, start_q.pop_front());
         end
         if (dout_valid) begin
            if (exp_q.size() == 0) begin
               flag("dout_unexpected", dout_idx, -1);
            end else begin
               e = exp_q.pop_front();
               check("dout_cycle", c, e.cyc);
               check("dout_idx", dout_idx, e.idx);
               check("duty_out", duty_out, e.duty);
               check("phase_out", phase_out, e.phase);
            end
            if (int'(dout_idx) < DEPTH) shadow[dout_idx] = int'(duty_out);
         end
         if (done) begin
            done_seen++;
            if (done_q.size() == 0) flag("done_unexpected", c, -1);
            else check("done_cycle", c, done_q.pop_front());
            committed = shadow;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   task automatic request();
      update = 1'b1;
      model_req(cyc);
      step();
      update = 1'b0;
   endtask

   task automatic load(input int mode, input int val);
      for (int i = 0; i < 256; i++) begin
         duty_mem[i]  = (mode == 0) ? val : int'($urandom_range(8191, 0));
         phase_mem[i] = (mode == 0) ? i   : int'($urandom_range(8191, 0));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_dout_valid"}, dout_valid, 0);
      check({tag, "_dout_idx"}, dout_idx, 0);
      check({tag, "_duty_out"}, duty_out, 0);
      check({tag, "_phase_out"}, phase_out, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overrun"}, overrun, 0);
   endtask

   task automatic count_buf(input string name, input int expv);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (committed[i] != expv) bad++;
      check(name, bad, 0);
   endtask

   task automatic scale_pass(input int m, input int d, input int expv, input bit toggle);
      int t0;
      load(0, d);
      pass_mod = m;
      mod = MOD_WIDTH'(m);
      t0 = cyc;
      request();
      if (toggle) begin
         wait_until(t0 + 5);
         for (int k = 0; k < 150; k++) begin
            mod = MOD_WIDTH'($urandom);
            step();
         end
         mod = MOD_WIDTH'(m);
      end
      wait_until(t0 + PASS_LEN + 3);
      check("scale_buf0", committed[0], expv);
      count_buf("scale_buf_all", expv);
   endtask

   initial begin
      #(10 * 40000);
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int d0;
      rst = 1'b1; update = 1'b0; mod = '0;
      load(0, 0);
      repeat (3) step();
      rst = 1'b0;
      check_zero("reset");
      mon_en = 1'b1;
      step();

      // Basic pass at full modulation.
      load(0, 2500);
      pass_mod = 255; mod = 8'd255;
      t0 = cyc;
      d0 = done_seen;
      request();
      wait_until(t0 + PASS_LEN);
      check("basic_busy_at_done", busy, 1);
      step();
      check("basic_busy_after", busy, 0);
      check("basic_passes", done_seen - d0, 1);
      count_buf("basic_buf_2500", 2500);
      step();

      // Scaling, including random MOD wiggles mid-pass.
      scale_pass(127, 2500, 1250, 1'b1);
      scale_pass(0, 8191, 31, 1'b0);
      scale_pass(255, 8191, 8191, 1'b1);

      // Queued request.
      load(1, 0);
      pass_mod = 255; mod = 8'd255;
      t0 = cyc; d0 = done_seen;
      request();
      wait_until(t0 + 10);
      request();
      wait_until(t0 + 2 * PASS_LEN + 3);
      check("queued_passes", done_seen - d0, 2);
      check("queued_overrun", overrun, 0);

      // Third request while pending is set.
      t0 = cyc; d0 = done_seen;
      request();
      wait_until(t0 + 10);
      request();
      wait_until(t0 + 20);
      request();
      wait_until(t0 + 3 * PASS_LEN + 3);
      check("overrun_passes", done_seen - d0, 2);
      check("overrun_sticky", overrun, 1);

      // Request landing in the commit cycle.
      pass_mod = 90; mod = 8'd90;
      t0 = cyc; d0 = done_seen;
      request();
      wait_until(t0 + PASS_LEN);
      check("collide_done_now", done, 1);
      request();
      check("collide_start_next", start, 1);
      wait_until(t0 + 2 * PASS_LEN + 3);
      check("collide_passes", done_seen - d0, 2);

      // Reset mid-pass with a pending request.
      t0 = cyc;
      request();
      wait_until(t0 + 50);
      request();
      wait_until(t0 + 100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete(); start_q.delete(); done_q.delete(); pass_l.delete();
      ovr_cycle = NEVER;
      check_zero("midreset");
      d0 = done_seen;
      wait_until(t0 + 2 * PASS_LEN + 10);
      check("midreset_no_done", done_seen - d0, 0);
      t0 = cyc;
      request();
      wait_until(t0 + PASS_LEN + 3);
      check("postreset_passes", done_seen - d0, 1);

      // Random data, MOD=200, then random MOD.
      load(1, 0);
      pass_mod = 200; mod = 8'd200;
      t0 = cyc;
      request();
      wait_until(t0 + PASS_LEN + 3);
      pass_mod = int'($urandom_range(255, 0)); mod = MOD_WIDTH'(pass_mod);
      t0 = cyc;
      request();
      wait_until(t0 + PASS_LEN + 3);

      repeat (4) step();
      check("leftover_expected", exp_q.size() + start_q.size() + done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
